// File: rtl/multi_clock_divider.sv
// multi_clock_divider
//   Multi-channel runtime-programmable clock/tick generator. Each of NUM_CH
//   channels divides clkIn by its own divisor D. It produces a near-50% square
//   wave (high for ceil(D/2) cycles) and a one-cycle tick at the start of every
//   period. A divisor written to an enabled channel is held in a shadow register
//   and applied at the next wrap edge, so period changes are glitch-free.
//   syncAll restarts every enabled channel in phase.
// Ports:
//   clkIn    in   1        sole clock, rising edge
//   resetN   in   1        synchronous active-low reset
//   wrEn     in   1        divisor write strobe
//   wrCh     in   CH_BITS  channel index for the write (>= NUM_CH is ignored)
//   wrDiv    in   WIDTH    new divisor (0 = disable, 1 = constant high)
//   syncAll  in   1        restart all enabled channels at a wrap edge
//   clkOut   out  NUM_CH   registered divided clock per channel
//   tick     out  NUM_CH   registered start-of-period strobe per channel
//   pending  out  NUM_CH   shadow divisor waiting for a period boundary
module multi_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50_000_000,
  localparam int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clkIn,
  input  logic               resetN,
  input  logic               wrEn,
  input  logic [CH_BITS-1:0] wrCh,
  input  logic [WIDTH-1:0]   wrDiv,
  input  logic               syncAll,
  output logic [NUM_CH-1:0]  clkOut,
  output logic [NUM_CH-1:0]  tick,
  output logic [NUM_CH-1:0]  pending
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // Counter value that makes the next edge a wrap edge.
  function automatic logic [WIDTH-1:0] preWrap(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    if (d <= ONE) r = ZERO;
    else          r = d - ONE;
    return r;
  endfunction

  // High-phase length ceil(d/2).
  function automatic logic [WIDTH-1:0] hiOf(input logic [WIDTH-1:0] d);
    return d - (d >> 1);
  endfunction

  logic wrValid;
  assign wrValid = wrEn && (int'(wrCh) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    logic [WIDTH-1:0] divR, shadowR, cntR;
    logic             pendR, clkR, tickR;
    logic [WIDTH-1:0] divN, shadowN, cntN;
    logic             pendN, clkN, tickN;
    logic             chWr;

    assign chWr = wrValid && (wrCh == CH_BITS'(i));

    // Next-state for one channel: sync restart, disabled load, or normal count.
    always_comb begin
      divN    = divR;
      shadowN = shadowR;
      pendN   = pendR;
      cntN    = cntR;
      clkN    = 1'b0;
      tickN   = 1'b0;
      if (syncAll) begin
        // A same-edge write beats any older shadow value.
        if (chWr)       divN = wrDiv;
        else if (pendR) divN = shadowR;
        else            divN = divR;
        pendN = 1'b0;
        cntN  = ZERO;
        if (divN != ZERO) begin
          tickN = 1'b1;
          clkN  = 1'b1;
        end else begin
          tickN = 1'b0;
          clkN  = 1'b0;
        end
      end else if (divR == ZERO) begin
        // Disabled: a write loads directly and arms a wrap on the next edge;
        // outputs stay low for this edge.
        if (chWr) begin
          divN = wrDiv;
          cntN = preWrap(wrDiv);
        end else begin
          cntN = ZERO;
        end
      end else begin
        if (cntR >= divR - ONE) begin
          // Wrap edge: the shadow divisor takes over here.
          if (pendR) divN = shadowR;
          else       divN = divR;
          pendN = 1'b0;
          cntN  = ZERO;
          if (divN != ZERO) begin
            tickN = 1'b1;
            clkN  = 1'b1;
          end else begin
            tickN = 1'b0;
            clkN  = 1'b0;
          end
        end else begin
          cntN  = cntR + ONE;
          clkN  = (cntN < hiOf(divR));
          tickN = 1'b0;
        end
        // A write here lands in the shadow and waits for the following wrap.
        if (chWr) begin
          shadowN = wrDiv;
          pendN   = 1'b1;
        end else begin
          shadowN = shadowN;
        end
      end
    end

    // Channel state and registered outputs with synchronous reset.
    always_ff @(posedge clkIn) begin
      if (!resetN) begin
        divR    <= DEF_DIV;
        shadowR <= DEF_DIV;
        pendR   <= 1'b0;
        cntR    <= preWrap(DEF_DIV);
        clkR    <= 1'b0;
        tickR   <= 1'b0;
      end else begin
        divR    <= divN;
        shadowR <= shadowN;
        pendR   <= pendN;
        cntR    <= cntN;
        clkR    <= clkN;
        tickR   <= tickN;
      end
    end

    assign clkOut[i]  = clkR;
    assign tick[i]    = tickR;
    assign pending[i] = pendR;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider. Two instances share stimulus:
// a 4-channel one and a 3-channel one, where writes to channel 3 are out of
// range and must be ignored, so the 3-channel outputs must track channels 0..2
// of the reference model.
module tb_multi_clock_divider;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int DEF = 4;

  logic           clkIn = 1'b0;
  logic           resetN = 1'b0;
  logic           wrEn = 1'b0;
  logic [1:0]     wrCh = 2'd0;
  logic [W-1:0]   wrDiv = 8'd0;
  logic           syncAll = 1'b0;
  logic [NCH-1:0] clkOut, tick, pending;
  logic [2:0]     clkOut3, tick3, pending3;

  int checks = 0;
  int errors = 0;

  // Reference model: divisor, shadow, pending, position within the period
  // (-1 means the next edge starts a fresh period).
  int  mD[NCH], mS[NCH], mP[NCH], mPos[NCH];
  bit  eClk[NCH], eTick[NCH];

  multi_clock_divider #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_DIV(DEF)) u0 (
    .clkIn(clkIn), .resetN(resetN), .wrEn(wrEn), .wrCh(wrCh), .wrDiv(wrDiv),
    .syncAll(syncAll), .clkOut(clkOut), .tick(tick), .pending(pending));

  multi_clock_divider #(.NUM_CH(3), .WIDTH(W), .DEFAULT_DIV(DEF)) u1 (
    .clkIn(clkIn), .resetN(resetN), .wrEn(wrEn), .wrCh(wrCh), .wrDiv(wrDiv),
    .syncAll(syncAll), .clkOut(clkOut3), .tick(tick3), .pending(pending3));

  always #5 clkIn = ~clkIn;

  task automatic checkVal(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs follow from position in the period: tick at position 0, high
  // for the first ceil(D/2) positions, all low when disabled.
  function automatic void setOutputs(input int c);
    if (mD[c] == 0) begin
      eClk[c] = 1'b0; eTick[c] = 1'b0;
    end else begin
      eTick[c] = (mPos[c] == 0);
      eClk[c]  = (mPos[c] < (mD[c] + 1) / 2);
    end
  endfunction

  task automatic modelEdge(input bit rN, input bit we, input int ch,
                           input int wd, input bit sy);
    for (int c = 0; c < NCH; c++) begin
      bit w;
      w = we && (ch == c);
      if (!rN) begin
        mD[c] = DEF; mS[c] = DEF; mP[c] = 0; mPos[c] = -1;
        eClk[c] = 1'b0; eTick[c] = 1'b0;
      end else if (sy) begin
        if (w) mD[c] = wd;
        else if (mP[c] != 0) mD[c] = mS[c];
        mP[c] = 0; mPos[c] = 0;
        setOutputs(c);
      end else if (mD[c] == 0) begin
        if (w) begin mD[c] = wd; mPos[c] = -1; end
        eClk[c] = 1'b0; eTick[c] = 1'b0;
      end else begin
        mPos[c] = mPos[c] + 1;
        if (mPos[c] >= mD[c]) mPos[c] = 0;
        if (mPos[c] == 0 && mP[c] != 0) begin
          mD[c] = mS[c]; mP[c] = 0;
        end
        setOutputs(c);
        if (w) begin mS[c] = wd; mP[c] = 1; end
      end
    end
  endtask

  task automatic compareAll();
    logic [NCH-1:0] ec, et, ep;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = eClk[c]; et[c] = eTick[c]; ep[c] = (mP[c] != 0);
    end
    checkVal("clkOut", int'(clkOut), int'(ec));
    checkVal("tick", int'(tick), int'(et));
    checkVal("pending", int'(pending), int'(ep));
    checkVal("clkOut3ch", int'(clkOut3), int'(ec[2:0]));
    checkVal("tick3ch", int'(tick3), int'(et[2:0]));
    checkVal("pending3ch", int'(pending3), int'(ep[2:0]));
  endtask

  task automatic runCycle(input bit rN, input bit we, input int ch,
                          input int wd, input bit sy);
    resetN = rN; wrEn = we; wrCh = ch[1:0]; wrDiv = wd[W-1:0]; syncAll = sy;
    @(posedge clkIn);
    modelEdge(rN, we, ch, wd, sy);
    @(negedge clkIn);
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) runCycle(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic writeCh(input int ch, input int wd);
    runCycle(1'b1, 1'b1, ch, wd, 1'b0);
  endtask

  initial begin
    // Reset, then default divide-by-4 on all channels in phase.
    for (int k = 0; k < 3; k++) runCycle(1'b0, 1'b0, 0, 0, 1'b0);
    idle(12);
    // Per-channel divisors: 5, constant-high 1, and disable.
    writeCh(1, 5);
    writeCh(2, 1);
    writeCh(3, 0);
    idle(20);
    // Wait for ch0 at position 1 of its period, then request D=8.
    for (int k = 0; k < 8 && mPos[0] != 1; k++) idle(1);
    writeCh(0, 8);
    idle(20);
    // Two writes before the boundary: last one wins.
    writeCh(0, 6);
    writeCh(0, 10);
    idle(25);
    // Drifting D=3 and D=4 channels, then realign with syncAll.
    writeCh(0, 3);
    writeCh(1, 4);
    idle(17);
    runCycle(1'b1, 1'b0, 0, 0, 1'b1);
    idle(6);
    // syncAll together with a write to the same channel, and to a disabled one.
    runCycle(1'b1, 1'b1, 1, 7, 1'b1);
    idle(4);
    runCycle(1'b1, 1'b1, 3, 2, 1'b1);
    idle(6);
    // Re-enable a disabled channel through a normal write.
    writeCh(3, 0);
    idle(8);
    writeCh(3, 3);
    idle(6);
    // Reset mid-period with a write pending.
    writeCh(1, 9);
    idle(1);
    runCycle(1'b0, 1'b0, 0, 0, 1'b0);
    idle(12);
    // Randomized phase.
    for (int k = 0; k < 400; k++) begin
      bit rN, we, sy;
      rN = ($urandom_range(0, 79) != 0);
      we = ($urandom_range(0, 3) == 0);
      sy = ($urandom_range(0, 39) == 0);
      runCycle(rN, we, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), sy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
